// File: rtl/wr_data_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : wr_data_serializer
//  Purpose  : Write-data queue plus DQ/DM/DQS serializer. It buffers whole
//             write bursts, then plays each one out beat by beat. Each burst
//             is framed by a DQS preamble and postamble. A back-to-back burst
//             on the final beat is chained seamlessly.
//  Revision : 1.0  initial release
// ============================================================================
module wr_data_serializer #(
   parameter int DQ_W   = 8,
   parameter int BL_MAX = 8,
   parameter int DEPTH  = 4
) (
   input  logic                     CK_t,
   input  logic                     reset_n,
   input  logic                     wr_push,
   input  logic                     wr_bc,
   input  logic                     wr_pre,
   input  logic [DQ_W*BL_MAX-1:0]   wr_data,
   input  logic [DQ_W/8*BL_MAX-1:0] wr_mask,
   input  logic                     wr_rdy,
   output logic [DQ_W-1:0]          dq,
   output logic                     dq_oe,
   output logic [DQ_W/8-1:0]        dm,
   output logic                     dqs_t,
   output logic                     dqs_c,
   output logic                     dqs_oe,
   output logic                     full,
   output logic                     empty,
   output logic                     busy,
   output logic                     burst_done,
   output logic                     overflow,
   output logic                     underflow
);

   localparam int c_DM_W = DQ_W / 8;
   localparam int c_BW   = $clog2(BL_MAX);
   localparam int c_PW   = $clog2(DEPTH);
   localparam int c_CW   = c_PW + 1;

   localparam logic [c_BW-1:0] c_LAST_FULL = c_BW'(BL_MAX - 1);
   localparam logic [c_BW-1:0] c_LAST_BC   = c_BW'(BL_MAX / 2 - 1);
   localparam logic [c_BW-1:0] c_BEAT_ONE  = c_BW'(1);
   localparam logic [c_PW-1:0] c_PTR_ONE   = c_PW'(1);
   localparam logic [c_CW-1:0] c_CNT_ONE   = c_CW'(1);
   localparam logic [c_CW-1:0] c_DEPTH     = c_CW'(DEPTH);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRE   = 2'd1,
      ST_BURST = 2'd2,
      ST_POST  = 2'd3
   } state_t;

   // ---------------------------------------------------------------- queue
   logic [BL_MAX-1:0][DQ_W-1:0]   r_q_data [DEPTH];
   logic [BL_MAX-1:0][c_DM_W-1:0] r_q_mask [DEPTH];
   logic                          r_q_bc   [DEPTH];
   logic                          r_q_pre  [DEPTH];

   logic [c_PW-1:0] r_wr_ptr;
   logic [c_PW-1:0] r_rd_ptr;
   logic [c_CW-1:0] r_count;
   logic            r_overflow;
   logic            r_underflow;

   // ------------------------------------------------------------- serializer
   state_t                        r_state;
   logic [c_BW-1:0]               r_beat;
   logic                          r_pre_two;
   logic                          r_cur_bc;
   logic [BL_MAX-1:0][DQ_W-1:0]   r_cur_data;
   logic [BL_MAX-1:0][c_DM_W-1:0] r_cur_mask;

   logic [DQ_W-1:0]   r_dq;
   logic [c_DM_W-1:0] r_dm;
   logic              r_dq_oe;
   logic              r_dqs_oe;
   logic              r_dqs_t;
   logic              r_dqs_c;
   logic              r_burst_done;

   logic                          w_empty;
   logic                          w_full;
   logic [c_BW-1:0]               w_cur_last;
   logic [c_BW-1:0]               w_head_last;
   logic [c_BW-1:0]               w_beat_nx;
   logic                          w_last_beat;
   logic                          w_pop;
   logic                          w_push;
   logic                          w_ovf_evt;
   logic                          w_udf_evt;
   logic                          w_head_bc;
   logic                          w_head_pre;
   logic [BL_MAX-1:0][DQ_W-1:0]   w_head_data;
   logic [BL_MAX-1:0][c_DM_W-1:0] w_head_mask;

   assign w_empty     = (r_count == '0);
   assign w_full      = (r_count == c_DEPTH);
   assign w_head_bc   = r_q_bc[r_rd_ptr];
   assign w_head_pre  = r_q_pre[r_rd_ptr];
   assign w_head_data = r_q_data[r_rd_ptr];
   assign w_head_mask = r_q_mask[r_rd_ptr];
   assign w_cur_last  = r_cur_bc ? c_LAST_BC : c_LAST_FULL;
   assign w_head_last = w_head_bc ? c_LAST_BC : c_LAST_FULL;
   assign w_beat_nx   = r_beat + c_BEAT_ONE;
   assign w_last_beat = (r_state == ST_BURST) && (r_beat == w_cur_last);

   // The head leaves the queue when a burst starts from IDLE or is chained on the final beat
   assign w_pop     = wr_rdy && !w_empty && ((r_state == ST_IDLE) || w_last_beat);
   // A full queue still accepts a push when the head is popped in the same cycle
   assign w_push    = wr_push && (!w_full || w_pop);
   assign w_ovf_evt = wr_push && w_full && !w_pop;
   assign w_udf_evt = wr_rdy && w_empty && (r_state == ST_IDLE);

   // Queue storage; contents are don't-care while unoccupied, so no reset is needed
   always_ff @(posedge CK_t) begin
      if (w_push) begin
         r_q_data[r_wr_ptr] <= wr_data;
         r_q_mask[r_wr_ptr] <= wr_mask;
         r_q_bc[r_wr_ptr]   <= wr_bc;
         r_q_pre[r_wr_ptr]  <= wr_pre;
      end
   end

   // Queue pointers, occupancy count and sticky error flags
   always_ff @(posedge CK_t or negedge reset_n) begin
      if (!reset_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_CNT_ONE;
            2'b01:   r_count <= r_count - c_CNT_ONE;
            default: r_count <= r_count;
         endcase
         if (w_ovf_evt) r_overflow  <= 1'b1;
         if (w_udf_evt) r_underflow <= 1'b1;
      end
   end

   // Serializer FSM; every pin output is registered and driven for the cycle it is entered
   always_ff @(posedge CK_t or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= ST_IDLE;
         r_beat       <= '0;
         r_pre_two    <= 1'b0;
         r_cur_bc     <= 1'b0;
         r_cur_data   <= '0;
         r_cur_mask   <= '0;
         r_dq         <= '0;
         r_dm         <= '0;
         r_dq_oe      <= 1'b0;
         r_dqs_oe     <= 1'b0;
         r_dqs_t      <= 1'b1;
         r_dqs_c      <= 1'b1;
         r_burst_done <= 1'b0;
      end else begin
         r_burst_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_pop) begin
                  r_cur_bc   <= w_head_bc;
                  r_cur_data <= w_head_data;
                  r_cur_mask <= w_head_mask;
                  r_state    <= ST_PRE;
                  r_dqs_oe   <= 1'b1;
                  r_dq_oe    <= 1'b0;
                  r_pre_two  <= w_head_pre;
                  // A two-cycle preamble opens with a high strobe, a one-cycle one goes straight low
                  r_dqs_t    <= w_head_pre;
                  r_dqs_c    <= ~w_head_pre;
               end
            end
            ST_PRE: begin
               if (r_pre_two) begin
                  r_pre_two <= 1'b0;
                  r_dqs_t   <= 1'b0;
                  r_dqs_c   <= 1'b1;
               end else begin
                  r_state      <= ST_BURST;
                  r_beat       <= '0;
                  r_dq         <= r_cur_data[0];
                  r_dm         <= r_cur_mask[0];
                  r_dq_oe      <= 1'b1;
                  r_dqs_t      <= 1'b1;
                  r_dqs_c      <= 1'b0;
                  r_burst_done <= (w_cur_last == '0);
               end
            end
            ST_BURST: begin
               if (w_last_beat) begin
                  if (w_pop) begin
                     // Seamless chain: next entry's beat 0 follows directly, strobe phase restarts
                     r_cur_bc     <= w_head_bc;
                     r_cur_data   <= w_head_data;
                     r_cur_mask   <= w_head_mask;
                     r_beat       <= '0;
                     r_dq         <= w_head_data[0];
                     r_dm         <= w_head_mask[0];
                     r_dqs_t      <= 1'b1;
                     r_dqs_c      <= 1'b0;
                     r_burst_done <= (w_head_last == '0);
                  end else begin
                     r_state <= ST_POST;
                     r_dq    <= '0;
                     r_dm    <= '0;
                     r_dq_oe <= 1'b0;
                     r_dqs_t <= 1'b0;
                     r_dqs_c <= 1'b1;
                  end
               end else begin
                  r_beat       <= w_beat_nx;
                  r_dq         <= r_cur_data[w_beat_nx];
                  r_dm         <= r_cur_mask[w_beat_nx];
                  r_dqs_t      <= ~w_beat_nx[0];
                  r_dqs_c      <= w_beat_nx[0];
                  r_burst_done <= (w_beat_nx == w_cur_last);
               end
            end
            ST_POST: begin
               r_state  <= ST_IDLE;
               r_dqs_oe <= 1'b0;
               r_dqs_t  <= 1'b1;
               r_dqs_c  <= 1'b1;
            end
            default: begin
               r_state  <= ST_IDLE;
               r_dq     <= '0;
               r_dm     <= '0;
               r_dq_oe  <= 1'b0;
               r_dqs_oe <= 1'b0;
               r_dqs_t  <= 1'b1;
               r_dqs_c  <= 1'b1;
            end
         endcase
      end
   end

   assign dq         = r_dq;
   assign dm         = r_dm;
   assign dq_oe      = r_dq_oe;
   assign dqs_oe     = r_dqs_oe;
   assign dqs_t      = r_dqs_t;
   assign dqs_c      = r_dqs_c;
   assign burst_done = r_burst_done;
   assign full       = w_full;
   assign empty      = w_empty;
   assign busy       = (r_state != ST_IDLE);
   assign overflow   = r_overflow;
   assign underflow  = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_wr_data_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wr_data_serializer
//  Purpose  : Directed self-checking bench for wr_data_serializer. An entry
//             model and an expected pin-state queue are filled when stimulus
//             is driven and consumed one entry per clock.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wr_data_serializer;

   typedef struct packed {
      logic        bc;
      logic        pre;
      logic [63:0] data;
      logic [7:0]  mask;
   } ent_t;

   logic        clk;
   logic        reset_n;
   logic        wr_push;
   logic        wr_bc;
   logic        wr_pre;
   logic [63:0] wr_data;
   logic [7:0]  wr_mask;
   logic        wr_rdy;
   logic [7:0]  dq;
   logic        dq_oe;
   logic [0:0]  dm;
   logic        dqs_t;
   logic        dqs_c;
   logic        dqs_oe;
   logic        full;
   logic        empty;
   logic        busy;
   logic        burst_done;
   logic        overflow;
   logic        underflow;

   int n_tests = 0;
   int n_fail  = 0;
   int n_out   = 0;

   ent_t        mq[$];
   logic [13:0] expq[$];

   wr_data_serializer #(.DQ_W(8), .BL_MAX(8), .DEPTH(4)) dut (
      .CK_t      (clk),
      .reset_n   (reset_n),
      .wr_push   (wr_push),
      .wr_bc     (wr_bc),
      .wr_pre    (wr_pre),
      .wr_data   (wr_data),
      .wr_mask   (wr_mask),
      .wr_rdy    (wr_rdy),
      .dq        (dq),
      .dq_oe     (dq_oe),
      .dm        (dm),
      .dqs_t     (dqs_t),
      .dqs_c     (dqs_c),
      .dqs_oe    (dqs_oe),
      .full      (full),
      .empty     (empty),
      .busy      (busy),
      .burst_done(burst_done),
      .overflow  (overflow),
      .underflow (underflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Expected pin word: {dq, dm, dq_oe, dqs_oe, dqs_t, dqs_c, burst_done}
   function automatic logic [13:0] pins(input logic [7:0] d, input logic m, input logic doe,
                                        input logic soe, input logic t, input logic c,
                                        input logic bd);
      return {d, m, doe, soe, t, c, bd};
   endfunction

   task automatic exp_pre(input logic two);
      if (two) expq.push_back(pins(8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
      expq.push_back(pins(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
   endtask

   task automatic exp_beats(input ent_t e);
      int n;
      n = e.bc ? 4 : 8;
      for (int k = 0; k < n; k++)
         expq.push_back(pins(e.data[k*8 +: 8], e.mask[k], 1'b1, 1'b1,
                             (k % 2) == 0, (k % 2) == 1, k == n - 1));
   endtask

   task automatic exp_post();
      expq.push_back(pins(8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0));
   endtask

   task automatic exp_idle();
      expq.push_back(pins(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
   endtask

   // One clock: sample #1 after the edge and compare against the next expected pin word
   task automatic step();
      logic [13:0] e;
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
         e = expq.pop_front();
         chk($sformatf("pins[%0d]", n_out), 64'({dq, dm, dq_oe, dqs_oe, dqs_t, dqs_c, burst_done}),
             64'(e));
         n_out++;
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 64; i++) begin
         if (expq.size() == 0) break;
         step();
      end
      chk("drain_timeout", 64'(expq.size()), 64'd0);
   endtask

   task automatic drive_entry(input ent_t e);
      wr_bc   = e.bc;
      wr_pre  = e.pre;
      wr_data = e.data;
      wr_mask = e.mask;
   endtask

   task automatic push_entry(input ent_t e);
      drive_entry(e);
      wr_push = 1'b1;
      if (mq.size() < 4) mq.push_back(e);
      step();
      wr_push = 1'b0;
   endtask

   // Queue expectations for a full stand-alone burst of the model's head entry
   task automatic expect_single();
      ent_t e;
      e = mq.pop_front();
      exp_pre(e.pre);
      exp_beats(e);
      exp_post();
      exp_idle();
   endtask

   initial begin
      ent_t a, b, c, d, r;
      ent_t ex[5];

      reset_n = 1'b1;
      wr_push = 1'b0;
      wr_rdy  = 1'b0;
      wr_bc   = 1'b0;
      wr_pre  = 1'b0;
      wr_data = '0;
      wr_mask = '0;
      #2 reset_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Reset state
      chk("rst_empty", 64'(empty), 64'd1);
      chk("rst_full", 64'(full), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_flags", 64'({overflow, underflow}), 64'd0);
      chk("rst_pins", 64'({dq, dm, dq_oe, dqs_oe, dqs_t, dqs_c, burst_done}),
          64'(pins(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0)));

      // Full burst, 1-cycle preamble; push on the very first edge out of reset
      a = '{bc: 1'b0, pre: 1'b0, data: 64'h0807060504030201, mask: 8'h00};
      reset_n = 1'b1;
      push_entry(a);
      chk("a_not_empty", 64'(empty), 64'd0);
      expect_single();
      wr_rdy = 1'b1;
      step();
      wr_rdy = 1'b0;
      chk("a_busy", 64'(busy), 64'd1);
      drain();
      chk("a_empty_after", 64'(empty), 64'd1);
      chk("a_idle_after", 64'(busy), 64'd0);

      // Chopped burst with 2-cycle preamble
      b = '{bc: 1'b1, pre: 1'b1, data: {$urandom, $urandom}, mask: 8'hA5};
      push_entry(b);
      expect_single();
      wr_rdy = 1'b1;
      step();
      wr_rdy = 1'b0;
      drain();

      // Seamless back-to-back: second wr_rdy on final beat, a stray wr_rdy mid-burst is ignored
      c = '{bc: 1'b0, pre: 1'b0, data: {$urandom, $urandom}, mask: 8'h3C};
      d = '{bc: 1'b0, pre: 1'b1, data: {$urandom, $urandom}, mask: 8'hC1};
      push_entry(c);
      push_entry(d);
      void'(mq.pop_front());
      void'(mq.pop_front());
      exp_pre(c.pre);
      exp_beats(c);
      exp_beats(d);
      exp_post();
      exp_idle();
      wr_rdy = 1'b1;
      step();                      // PRE
      wr_rdy = 1'b0;
      step();                      // beat 0
      wr_rdy = 1'b1;
      step();                      // beat 1, wr_rdy sampled on beat 0 -> ignored
      wr_rdy = 1'b0;
      repeat (6) step();           // beats 2..7
      wr_rdy = 1'b1;
      step();                      // first beat of d
      wr_rdy = 1'b0;
      drain();
      chk("b2b_empty", 64'(empty), 64'd1);
      chk("b2b_no_udf", 64'(underflow), 64'd0);

      // Underflow: wr_rdy with empty queue in IDLE
      exp_idle();
      wr_rdy = 1'b1;
      step();
      wr_rdy = 1'b0;
      chk("udf_flag", 64'(underflow), 64'd1);
      chk("udf_idle", 64'(busy), 64'd0);

      // Fill to DEPTH, overflow on the fifth push, then push+pop while full
      for (int i = 0; i < 5; i++)
         ex[i] = '{bc: 1'(i % 2), pre: 1'b0, data: {$urandom, $urandom}, mask: 8'(i * 17)};
      for (int i = 0; i < 4; i++) push_entry(ex[i]);
      chk("fill_full", 64'(full), 64'd1);
      chk("fill_no_ovf", 64'(overflow), 64'd0);
      push_entry(ex[4]);
      chk("ovf_flag", 64'(overflow), 64'd1);
      chk("ovf_full", 64'(full), 64'd1);
      expect_single();
      mq.push_back(ex[4]);
      drive_entry(ex[4]);
      wr_push = 1'b1;
      wr_rdy  = 1'b1;
      step();
      wr_push = 1'b0;
      wr_rdy  = 1'b0;
      chk("pushpop_full", 64'(full), 64'd1);
      drain();
      chk("pushpop_still_full", 64'(full), 64'd1);

      // Asynchronous reset during beat 3 of the next burst (ex[1]: 1-cycle preamble)
      expect_single();
      wr_rdy = 1'b1;
      step();                      // PRE
      wr_rdy = 1'b0;
      repeat (4) step();           // beats 0..3
      #2 reset_n = 1'b0;
      #1;
      chk("arst_oe", 64'({dq_oe, dqs_oe}), 64'd0);
      chk("arst_dqs", 64'({dqs_t, dqs_c}), 64'd3);
      chk("arst_empty", 64'(empty), 64'd1);
      chk("arst_full", 64'(full), 64'd0);
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_flags", 64'({overflow, underflow, burst_done}), 64'd0);
      expq.delete();
      mq.delete();
      @(posedge clk);
      #1;

      // Clean burst after reset release
      r = '{bc: 1'b1, pre: 1'b0, data: {$urandom, $urandom}, mask: 8'h0F};
      reset_n = 1'b1;
      push_entry(r);
      chk("post_rst_push", 64'(empty), 64'd0);
      expect_single();
      wr_rdy = 1'b1;
      step();
      wr_rdy = 1'b0;
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global watchdog so the run always terminates
   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/wr_data_serializer.md
WR_DATA_SERIALIZER -- requirements
Module: wr_data_serializer

Interface
REQ-001 Parameter DQ_W, default 8, width of the DQ/DM beat (DM width = DQ_W/8).
REQ-002 Parameter BL_MAX, default 8, beats in a full burst; chopped burst = BL_MAX/2.
REQ-003 Parameter DEPTH, default 4, write-data queue entries (power of two, >=2).
REQ-004 CK_t  in  1  sole clock; all state changes on rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 wr_push  in  1  enqueue request (controller act_rdy | no_act_rdy).
REQ-007 wr_bc  in  1  entry burst mode: 0 = BL_MAX beats, 1 = BL_MAX/2 beats (chop).
REQ-008 wr_pre  in  1  entry preamble: 0 = 1 cycle, 1 = 2 cycles.
REQ-009 wr_data  in  DQ_W*BL_MAX  burst payload, beat 0 in LSBs.
REQ-010 wr_mask  in  DQ_W/8*BL_MAX  per-byte data mask, beat 0 in LSBs.
REQ-011 wr_rdy  in  1  one-cycle pulse: start transmitting head entry.
REQ-012 dq  out  DQ_W  data beat; dq_oe  out  1  DQ drive enable.
REQ-013 dm  out  DQ_W/8  mask beat, valid when dq_oe = 1.
REQ-014 dqs_t, dqs_c  out  1 each  strobe pair; dqs_oe  out  1  strobe drive enable.
REQ-015 full, empty  out  1 each  queue status; busy  out  1  state != IDLE.
REQ-016 burst_done  out  1  one-cycle pulse on final data beat of each burst.
REQ-017 overflow, underflow  out  1 each  sticky error flags, cleared only by reset.

Function
REQ-018 Queue SHALL be a DEPTH-entry FIFO of {wr_bc, wr_pre, wr_data, wr_mask}; wr_push writes at the rising edge it is sampled.
REQ-019 wr_push while full (with no pop that cycle) SHALL be dropped and set overflow; push and pop in the same cycle while full SHALL both succeed.
REQ-020 wr_rdy while empty and IDLE SHALL be ignored and set underflow.
REQ-021 FSM states: IDLE, PRE, BURST, POST; pop of head entry occurs on the edge leaving IDLE (or seamless reload, REQ-026).
REQ-022 IDLE: dq_oe = dqs_oe = 0, dq = 0, dm = 0, dqs_t = dqs_c = 1.
REQ-023 IDLE -> PRE on edge where wr_rdy = 1 and empty = 0; first PRE outputs appear the cycle after wr_rdy is sampled (latency 1).
REQ-024 PRE lasts 1 or 2 cycles per entry wr_pre; dqs_oe = 1, dq_oe = 0; last PRE cycle dqs_t = 0 / dqs_c = 1; for 2-cycle preamble first cycle dqs_t = 1 / dqs_c = 0.
REQ-025 BURST lasts 8 or 4 cycles (BL_MAX or BL_MAX/2); beat k drives dq = wr_data[k*DQ_W +: DQ_W], dm = matching mask slice, dq_oe = 1, dqs_t = 1 for even k and 0 for odd k, dqs_c = !dqs_t.
REQ-026 wr_rdy sampled during the final beat with empty = 0 SHALL reload the next entry and continue BURST on the next cycle with no PRE/POST (seamless back-to-back); strobe phase restarts at k = 0.
REQ-027 Otherwise final beat -> POST; POST lasts 1 cycle: dqs_oe = 1, dqs_t = 0, dqs_c = 1, dq_oe = 0; then IDLE.
REQ-028 wr_rdy sampled in PRE, POST or non-final BURST cycles SHALL be ignored (no error flag).
REQ-029 burst_done SHALL assert exactly once per burst, coincident with the final beat.
REQ-030 Beat counter width SHALL be clog2(BL_MAX); pointers wrap modulo DEPTH; count width clog2(DEPTH)+1.

Reset
REQ-031 reset_n low SHALL immediately force IDLE outputs (REQ-022), empty = 1, full = 0, busy = 0, burst_done = 0, overflow = underflow = 0, queue emptied; mid-burst data is discarded.
REQ-032 First wr_push honoured on the first rising edge with reset_n = 1.

Verification
REQ-033 Push {bc=0, pre=0, data=0x0807060504030201}, wr_rdy -> 1 PRE cycle, dq = 01..08 on 8 consecutive cycles, dqs_t 1,0,1,0,1,0,1,0, burst_done on beat 7, 1 POST, IDLE.
REQ-034 Push {bc=1, pre=1}, wr_rdy -> 2 PRE cycles (dqs_t 1 then 0), 4 data beats, POST.
REQ-035 Push two entries, wr_rdy at start, second wr_rdy on beat 7 -> 16 contiguous beats, no PRE/POST between, two burst_done pulses.
REQ-036 DEPTH = 4: push 5 with no pops -> full after 4th, overflow = 1, 5th dropped; same-cycle push+pop while full -> count stays 4.
REQ-037 wr_rdy while empty -> underflow = 1, state stays IDLE; reset_n low during beat 3 -> dq_oe = dqs_oe = 0 and dqs_t = dqs_c = 1 asynchronously, queue empty.
